hatch_arbiter: RTL and testbench

- Shares one instruction-memory read port (hatch) among NUM_REQ fetch requesters, such as multiple cpu_fetch instances or a fetch plus a debug/loader reader.
- Round-robin grant, one read issued per cycle, fixed memory read latency.
- Tracks each in-flight read with a tag pipeline and steers the returned instruction word to its requester.
- A per-requester flush discards that requester's in-flight reads, for use on pipeline kill/branch redirect.

---
 rtl/hatch_arbiter.sv | 85 ++++++++
 tb/tb_hatch_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/hatch_arbiter.sv
// rtl/hatch_arbiter.sv - round-robin arbiter sharing one fixed-latency instruction read port
module hatch_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 48,
  parameter int RD_LAT  = 2,
  parameter int IDX_W   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ-1:0]        flush,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      mem_en,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic [DATA_W-1:0]         mem_rdata
);

  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   win;
  logic [IDX_W-1:0]   ptr_next;
  logic               found;
  logic [NUM_REQ-1:0] elig;

  logic [RD_LAT-1:0]            tag_v;
  logic [RD_LAT-1:0][IDX_W-1:0] tag_idx;

  assign elig = req & ~flush;

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDX_W'(s);
  endfunction

  // Scan starting at ptr so the most recently served requester goes last.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && elig[wrap_add(ptr, k)]) begin
        found = 1'b1;
        win   = wrap_add(ptr, k);
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (found && !rst) gnt[win] = 1'b1;
  end

  assign mem_en   = found & ~rst;
  assign mem_addr = mem_en ? addr[int'(win)*ADDR_W +: ADDR_W] : '0;
  assign ptr_next = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr     <= '0;
      tag_v   <= '0;
      tag_idx <= '0;
      rvalid  <= '0;
      rdata   <= '0;
    end else begin
      if (mem_en) ptr <= ptr_next;
      tag_v[0]   <= mem_en;
      tag_idx[0] <= win;
      // An entry moving between stages is dropped if its owner flushes this cycle.
      for (int k = 1; k < RD_LAT; k++) begin
        tag_v[k]   <= tag_v[k-1] & ~flush[tag_idx[k-1]];
        tag_idx[k] <= tag_idx[k-1];
      end
      rvalid <= '0;
      if (tag_v[RD_LAT-1] && !flush[tag_idx[RD_LAT-1]]) begin
        rvalid[tag_idx[RD_LAT-1]] <= 1'b1;
        rdata                     <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_hatch_arbiter.sv
// tb/tb_hatch_arbiter.sv - self-checking bench for hatch_arbiter against a scoreboard model
module tb_hatch_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 48;
  localparam int RD_LAT  = 2;
  localparam int IDX_W   = 2;

  logic                      clk;
  logic                      rst;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] addr;
  logic [NUM_REQ-1:0]        flush;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        rvalid;
  logic [DATA_W-1:0]         rdata;
  logic                      mem_en;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_rdata;

  hatch_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .flush(flush), .gnt(gnt),
    .rvalid(rvalid), .rdata(rdata), .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] data_of(input logic [ADDR_W-1:0] a);
    if (a == 32'h100) return 48'hABCD;
    return {a ^ 32'hC3A5_0F1E, a[15:0]};
  endfunction

  // Memory: returns data for the address presented RD_LAT cycles earlier.
  logic [ADDR_W-1:0] mline [RD_LAT];
  always @(posedge clk) begin
    mline[0] <= mem_addr;
    for (int k = 1; k < RD_LAT; k++) mline[k] <= mline[k-1];
  end
  assign mem_rdata = data_of(mline[RD_LAT-1]);

  typedef struct {
    int              due;
    int              idx;
    logic [DATA_W-1:0] data;
  } resp_t;

  typedef struct {
    logic [3:0] req;
    logic [3:0] flush;
    logic [3:0] gnt;
  } vec_t;

  resp_t pend[$];
  int    mptr;
  int    cyc;
  int    passed;
  int    total;
  logic [3:0]        last_gnt;
  logic [3:0]        last_rv;
  logic [DATA_W-1:0] last_rd;
  logic [ADDR_W-1:0] last_maddr;
  vec_t vecs[13];
  logic [127:0] fixed_addr;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, got, exp);
  endtask

  // One clock cycle: drive inputs, compare against the model, then advance the model.
  task automatic step(input logic [3:0] r, input logic [3:0] f, input logic [127:0] a);
    logic [3:0]        el;
    logic [3:0]        eg;
    logic [3:0]        erv;
    logic [DATA_W-1:0] erd;
    logic [ADDR_W-1:0] ea;
    int                w;
    resp_t             keep[$];
    @(negedge clk);
    req = r; flush = f; addr = a;
    #1;
    el = r & ~f;
    eg = '0;
    w  = -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      int j;
      j = (mptr + k) % NUM_REQ;
      if (w < 0 && el[j]) w = j;
    end
    if (w >= 0) eg[w] = 1'b1;
    ea = (w >= 0) ? a[w*ADDR_W +: ADDR_W] : '0;
    erv = '0;
    erd = '0;
    foreach (pend[n]) if (pend[n].due == cyc) begin
      erv[pend[n].idx] = 1'b1;
      erd = pend[n].data;
    end
    chk("gnt", 64'(gnt), 64'(eg));
    chk("mem_en", 64'(mem_en), 64'(w >= 0));
    chk("mem_addr", 64'(mem_addr), 64'(ea));
    chk("rvalid", 64'(rvalid), 64'(erv));
    if (erv != 0) chk("rdata", 64'(rdata), 64'(erd));
    last_gnt = gnt; last_rv = rvalid; last_rd = rdata; last_maddr = mem_addr;
    foreach (pend[n]) if (pend[n].due > cyc && !f[pend[n].idx]) keep.push_back(pend[n]);
    if (w >= 0) begin
      keep.push_back('{cyc + RD_LAT + 1, w, data_of(ea)});
      mptr = (w + 1) % NUM_REQ;
    end
    pend = keep;
    cyc++;
  endtask

  initial begin
    passed = 0; total = 0; cyc = 0; mptr = 0;
    fixed_addr = {32'h300, 32'h200, 32'h100, 32'h000};
    vecs[0]  = '{4'b0000, 4'b0000, 4'b0000};
    vecs[1]  = '{4'b0010, 4'b0000, 4'b0010};
    vecs[2]  = '{4'b1111, 4'b0000, 4'b0100};
    vecs[3]  = '{4'b1111, 4'b0000, 4'b1000};
    vecs[4]  = '{4'b1111, 4'b0000, 4'b0001};
    vecs[5]  = '{4'b1111, 4'b0000, 4'b0010};
    vecs[6]  = '{4'b1000, 4'b0000, 4'b1000};
    vecs[7]  = '{4'b0101, 4'b0000, 4'b0001};
    vecs[8]  = '{4'b0101, 4'b0000, 4'b0100};
    vecs[9]  = '{4'b1000, 4'b0000, 4'b1000};
    vecs[10] = '{4'b0011, 4'b0001, 4'b0010};
    vecs[11] = '{4'b1111, 4'b1111, 4'b0000};
    vecs[12] = '{4'b0001, 4'b0000, 4'b0001};

    rst = 1'b1; req = 4'b1111; flush = '0; addr = fixed_addr;
    #1;
    chk("reset_gnt", 64'(gnt), 64'h0);
    chk("reset_mem_en", 64'(mem_en), 64'h0);
    chk("reset_rvalid", 64'(rvalid), 64'h0);
    @(negedge clk);
    rst = 1'b0; req = '0;

    for (int i = 0; i < 13; i++) begin
      step(vecs[i].req, vecs[i].flush, fixed_addr);
      chk($sformatf("tbl_gnt_%0d", i), 64'(last_gnt), 64'(vecs[i].gnt));
    end
    for (int i = 0; i < 4; i++) step('0, '0, fixed_addr);

    // Single requester: ptr is 1 here; response lands three cycles after the grant.
    step(4'b0010, '0, fixed_addr);
    chk("single_gnt", 64'(last_gnt), 64'h2);
    chk("single_maddr", 64'(last_maddr), 64'h100);
    step('0, '0, fixed_addr);
    chk("single_rv_t1", 64'(last_rv), 64'h0);
    step('0, '0, fixed_addr);
    chk("single_rv_t2", 64'(last_rv), 64'h0);
    step('0, '0, fixed_addr);
    chk("single_rv_t3", 64'(last_rv), 64'h2);
    chk("single_rdata", 64'(last_rd), 64'hABCD);

    // Flush of requester 2 one cycle after its grant; requester 0 unaffected.
    step(4'b0100, '0, fixed_addr);
    chk("flush_gnt2", 64'(last_gnt), 64'h4);
    step(4'b0001, 4'b0100, fixed_addr);
    chk("flush_gnt0", 64'(last_gnt), 64'h1);
    step('0, '0, fixed_addr);
    step('0, '0, fixed_addr);
    chk("flush_no_rv2", 64'(last_rv), 64'h0);
    step('0, '0, fixed_addr);
    chk("flush_rv0", 64'(last_rv), 64'h1);

    for (int i = 0; i < 400; i++) begin
      logic [3:0]   r;
      logic [3:0]   f;
      logic [127:0] a;
      r = 4'($urandom);
      for (int b = 0; b < NUM_REQ; b++) f[b] = ($urandom_range(0, 5) == 0);
      a = {$urandom(), $urandom(), $urandom(), $urandom()};
      step(r, f, a);
    end

    // Asynchronous reset with reads in flight.
    step(4'b1111, '0, fixed_addr);
    step(4'b1111, '0, fixed_addr);
    step(4'b1111, '0, fixed_addr);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_gnt", 64'(gnt), 64'h0);
    chk("midrst_mem_en", 64'(mem_en), 64'h0);
    chk("midrst_rvalid", 64'(rvalid), 64'h0);
    #1 rst = 1'b0;
    req = '0;
    pend.delete();
    mptr = 0;
    for (int i = 0; i < 4; i++) begin
      step('0, '0, fixed_addr);
      chk($sformatf("postrst_rv_%0d", i), 64'(last_rv), 64'h0);
    end
    step(4'b0110, '0, fixed_addr);
    chk("postrst_gnt", 64'(last_gnt), 64'h2);
    for (int i = 0; i < 4; i++) step('0, '0, fixed_addr);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
